// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a one-word holding buffer
// so back-to-back words leave with no idle gap between frames.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [CW-1:0]    cnt, cnt_n;

    logic             accept;
    logic             at_end;
    logic [WIDTH-1:0] shifted;

    assign ready  = ~res & ~hold_full;
    assign accept = load & ready;
    assign at_end = (state == SHIFT) && (cnt == CNT_LAST);

    // Shift toward whichever end feeds sout, zero-filling behind.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign shifted = {1'b0, sreg[WIDTH-1:1]};
        end
    endgenerate

    assign sout_valid = (state == SHIFT);
    assign last       = at_end;
    assign sout       = sout_valid &
                        (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            sreg      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            cnt       <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        cnt_n       = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    sreg_n  = d;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (!at_end) begin
                    sreg_n = shifted;
                    cnt_n  = cnt + CW'(1);
                    if (accept) begin
                        hold_n      = d;
                        hold_full_n = 1'b1;
                    end
                end else if (hold_full) begin
                    sreg_n      = hold;
                    hold_full_n = 1'b0;
                    cnt_n       = '0;
                end else if (accept) begin
                    // Word arriving on the last edge skips the buffer.
                    sreg_n = d;
                    cnt_n  = '0;
                end else begin
                    sreg_n  = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx, one MSB-first and one
// LSB-first instance, each with its own expected-bit and frame-length queues.
module tb_piso_tx;

    logic       clk;
    logic       res_m, load_m;
    logic [3:0] d_m;
    logic       ready_m, sout_m, valid_m, last_m;
    logic       res_l, load_l;
    logic [3:0] d_l;
    logic       ready_l, sout_l, valid_l, last_l;

    int checks = 0;
    int errors = 0;

    logic [1:0] expq_m[$];
    logic [1:0] expq_l[$];
    int         lenq_m[$];
    int         lenq_l[$];
    int         run_m = 0;
    int         run_l = 0;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .res(res_m), .load(load_m), .d(d_m),
        .ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .last(last_m)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .res(res_l), .load(load_l), .d(d_l),
        .ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .last(last_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // seq[3] is the first bit expected on the line
    task automatic push_frame(input bit lsb, input logic [3:0] seq);
        for (int i = 0; i < 4; i++) begin
            if (lsb) expq_l.push_back({i == 3, seq[3-i]});
            else     expq_m.push_back({i == 3, seq[3-i]});
        end
    endtask

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        int         len;
        if (res_m) begin
            run_m = 0;
        end else if (valid_m) begin
            checks++;
            if (expq_m.size() == 0) begin
                errors++;
                $display("FAIL msb_unexpected_bit: got sout=%b last=%b, none expected",
                         sout_m, last_m);
            end else begin
                e = expq_m.pop_front();
                if ({last_m, sout_m} !== e) begin
                    errors++;
                    $display("FAIL msb_bit: got last,sout=%b%b expected %b",
                             last_m, sout_m, e);
                end
            end
            run_m++;
        end else if (run_m != 0) begin
            checks++;
            len = (lenq_m.size() == 0) ? -1 : lenq_m.pop_front();
            if (run_m != len) begin
                errors++;
                $display("FAIL msb_frame_len: got %0d expected %0d", run_m, len);
            end
            run_m = 0;
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        int         len;
        if (res_l) begin
            run_l = 0;
        end else if (valid_l) begin
            checks++;
            if (expq_l.size() == 0) begin
                errors++;
                $display("FAIL lsb_unexpected_bit: got sout=%b last=%b, none expected",
                         sout_l, last_l);
            end else begin
                e = expq_l.pop_front();
                if ({last_l, sout_l} !== e) begin
                    errors++;
                    $display("FAIL lsb_bit: got last,sout=%b%b expected %b",
                             last_l, sout_l, e);
                end
            end
            run_l++;
        end else if (run_l != 0) begin
            checks++;
            len = (lenq_l.size() == 0) ? -1 : lenq_l.pop_front();
            if (run_l != len) begin
                errors++;
                $display("FAIL lsb_frame_len: got %0d expected %0d", run_l, len);
            end
            run_l = 0;
        end
    end

    initial begin
        bit drained;
        res_m = 1'b1; load_m = 1'b0; d_m = 4'h0;
        res_l = 1'b1; load_l = 1'b0; d_l = 4'h0;
        repeat (2) tick();
        chk("rst_sout", sout_m, 1'b0);
        chk("rst_valid", valid_m, 1'b0);
        chk("rst_last", last_m, 1'b0);
        chk("rst_ready", ready_m, 1'b0);
        res_m = 1'b0;
        #1;
        chk("rel_ready", ready_m, 1'b1);
        tick();

        // single word 1001
        load_m = 1'b1; d_m = 4'b1001;
        push_frame(1'b0, 4'b1001); lenq_m.push_back(4);
        tick();
        load_m = 1'b0;
        repeat (6) tick();

        // back-to-back through hold, with an ignored load
        load_m = 1'b1; d_m = 4'b1001;
        push_frame(1'b0, 4'b1001); lenq_m.push_back(8);
        tick();
        load_m = 1'b0;
        tick();
        load_m = 1'b1; d_m = 4'b1010;
        push_frame(1'b0, 4'b1010);
        tick();
        chk("hold_ready_lo0", ready_m, 1'b0);
        load_m = 1'b1; d_m = 4'b1111;
        tick();
        load_m = 1'b0;
        chk("hold_ready_lo1", ready_m, 1'b0);
        chk("hold_last", last_m, 1'b1);
        tick();
        chk("hold_ready_hi", ready_m, 1'b1);
        repeat (6) tick();

        // bypass on the last edge
        load_m = 1'b1; d_m = 4'b1100;
        push_frame(1'b0, 4'b1100); lenq_m.push_back(8);
        tick();
        load_m = 1'b0;
        repeat (3) tick();
        chk("byp_last", last_m, 1'b1);
        chk("byp_ready_last", ready_m, 1'b1);
        load_m = 1'b1; d_m = 4'b0011;
        push_frame(1'b0, 4'b0011);
        tick();
        load_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("byp_ready", ready_m, 1'b1);
            tick();
        end
        repeat (6) tick();

        // reset mid-frame during bit 2 of 0110
        load_m = 1'b1; d_m = 4'b0110;
        push_frame(1'b0, 4'b0110); lenq_m.push_back(4);
        tick();
        load_m = 1'b0;
        repeat (2) tick();
        chk("pre_rst_sout", sout_m, 1'b1);
        chk("pre_rst_valid", valid_m, 1'b1);
        #2;
        res_m = 1'b1;
        #1;
        chk("mid_rst_sout", sout_m, 1'b0);
        chk("mid_rst_valid", valid_m, 1'b0);
        chk("mid_rst_last", last_m, 1'b0);
        chk("mid_rst_ready", ready_m, 1'b0);
        expq_m.delete();
        lenq_m.delete();
        repeat (2) tick();
        #2;
        res_m = 1'b0;
        #1;
        chk("post_rst_ready", ready_m, 1'b1);
        repeat (4) tick();
        load_m = 1'b1; d_m = 4'b0101;
        push_frame(1'b0, 4'b0101); lenq_m.push_back(4);
        tick();
        load_m = 1'b0;
        repeat (6) tick();

        // LSB-first instance: 1010 goes out as 0,1,0,1
        res_l = 1'b0;
        #1;
        chk("lsb_ready", ready_l, 1'b1);
        tick();
        load_l = 1'b1; d_l = 4'b1010;
        push_frame(1'b1, 4'b0101); lenq_l.push_back(4);
        tick();
        load_l = 1'b0;

        drained = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (expq_m.size() == 0 && expq_l.size() == 0 &&
                lenq_m.size() == 0 && lenq_l.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        chk("drain_timeout", drained, 1'b1);
        chk("msb_queue_empty", expq_m.size() == 0, 1'b1);
        chk("lsb_queue_empty", expq_l.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
